// File: rtl/victim_cache_ctrl_pkg.sv
// Shared types and constants for the 4-way victim cache controller.
// Imported by the tag matcher and the controller top.
package victim_cache_ctrl_pkg;

    localparam int VC_WAYS     = 4;
    localparam int VC_OFFSET_W = 4;

    typedef logic [1:0] vc_way_t;

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_WRITEBACK,
        VC_FETCH,
        VC_RESPOND
    } vc_state_t;

endpackage

// File: rtl/vc_tag_match.sv
// Combinational 4-way tag compare with hit-way encode and
// lowest-index invalid-way priority encode.
module vc_tag_match
    import victim_cache_ctrl_pkg::*;
#(
    parameter int TAG_W = 12
) (
    input  logic [VC_WAYS-1:0] valid,
    input  logic [TAG_W-1:0]   tags [VC_WAYS],
    input  logic [TAG_W-1:0]   tag,
    output logic               hit,
    output vc_way_t            hit_way,
    output logic               has_invalid,
    output vc_way_t            invalid_way
);

    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        invalid_way = '0;
        // Descending scan so the lowest index wins.
        for (int i = VC_WAYS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == tag) begin
                hit     = 1'b1;
                hit_way = vc_way_t'(i);
            end
            if (!valid[i]) begin
                has_invalid = 1'b1;
                invalid_way = vc_way_t'(i);
            end
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Fully-associative 4-entry victim cache between L1 and memory:
// swaps lines on hit, fetches and absorbs the L1 victim on miss.
module victim_cache_ctrl
    import victim_cache_ctrl_pkg::*;
#(
    parameter int TAG_W  = 12,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1_req,
    input  logic [TAG_W-1:0]  l1_tag,
    input  logic              l1_vict_vld,
    input  logic              l1_vict_dirty,
    input  logic [TAG_W-1:0]  l1_vict_tag,
    input  logic [LINE_W-1:0] l1_vict_data,
    output logic              l1_resp,
    output logic [LINE_W-1:0] l1_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              lru_load,
    output vc_way_t           lru_used_way,
    input  vc_way_t           lru_way
);

    vc_state_t            state, state_nxt;
    logic [VC_WAYS-1:0]   valid, dirty, dup;
    logic [TAG_W-1:0]     tags [VC_WAYS];
    logic [LINE_W-1:0]    data [VC_WAYS];
    vc_way_t              way_q, hit_way, invalid_way, pick, ins_way;
    logic                 hit_q, hit, has_invalid, need_wb, ins;
    logic [LINE_W-1:0]    line_q;

    vc_tag_match #(.TAG_W(TAG_W)) u_match (
        .valid       (valid),
        .tags        (tags),
        .tag         (l1_tag),
        .hit         (hit),
        .hit_way     (hit_way),
        .has_invalid (has_invalid),
        .invalid_way (invalid_way)
    );

    // Invalid ways take precedence over the (unreset) LRU tracker.
    assign pick    = has_invalid ? invalid_way : lru_way;
    assign need_wb = valid[pick] & dirty[pick] & l1_vict_vld;

    always_comb begin
        for (int i = 0; i < VC_WAYS; i++)
            dup[i] = valid[i] && tags[i] == l1_vict_tag;
    end

    always_comb begin
        ins     = 1'b0;
        ins_way = way_q;
        if (state == VC_IDLE && l1_req && hit && l1_vict_vld) begin
            ins     = 1'b1;
            ins_way = hit_way;
        end else if (state == VC_RESPOND && !hit_q && l1_vict_vld) begin
            ins = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= VC_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        l1_resp      = 1'b0;
        l1_rdata     = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        lru_load     = 1'b0;
        lru_used_way = '0;
        unique case (state)
            VC_IDLE: begin
                if (l1_req)
                    state_nxt = hit     ? VC_RESPOND :
                                need_wb ? VC_WRITEBACK : VC_FETCH;
            end
            VC_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[way_q], {VC_OFFSET_W{1'b0}}};
                pmem_wdata   = data[way_q];
                if (pmem_resp) state_nxt = VC_FETCH;
            end
            VC_FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {l1_tag, {VC_OFFSET_W{1'b0}}};
                if (pmem_resp) state_nxt = VC_RESPOND;
            end
            VC_RESPOND: begin
                l1_resp      = 1'b1;
                l1_rdata     = line_q;
                lru_load     = hit_q | l1_vict_vld;
                lru_used_way = way_q;
                state_nxt    = VC_IDLE;
            end
            default: state_nxt = VC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= '0;
            dirty  <= '0;
            hit_q  <= 1'b0;
            way_q  <= '0;
            line_q <= '0;
        end else begin
            unique case (state)
                VC_IDLE: begin
                    if (l1_req) begin
                        hit_q <= hit;
                        if (hit) begin
                            way_q  <= hit_way;
                            line_q <= data[hit_way];
                            if (!l1_vict_vld) valid[hit_way] <= 1'b0;
                        end else begin
                            way_q <= pick;
                        end
                    end
                end
                VC_WRITEBACK: if (pmem_resp) dirty[way_q] <= 1'b0;
                VC_FETCH:     if (pmem_resp) line_q <= pmem_rdata;
                default: ;
            endcase
            // Drop any stale copy so tags stay unique.
            if (ins) begin
                for (int i = 0; i < VC_WAYS; i++)
                    if (dup[i] && vc_way_t'(i) != ins_way) valid[i] <= 1'b0;
                valid[ins_way] <= 1'b1;
                dirty[ins_way] <= l1_vict_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ins) begin
            tags[ins_way] <= l1_vict_tag;
            data[ins_way] <= l1_vict_data;
        end
    end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Randomized bench for victim_cache_ctrl against a behavioural
// model of the cache contents and a latency-jittered memory.
module tb_victim_cache_ctrl;
    import victim_cache_ctrl_pkg::*;

    logic          clk, rst_n;
    logic          l1_req, l1_vict_vld, l1_vict_dirty;
    logic [11:0]   l1_tag, l1_vict_tag;
    logic [127:0]  l1_vict_data, l1_rdata, pmem_wdata, pmem_rdata;
    logic          l1_resp, pmem_read, pmem_write, pmem_resp, lru_load;
    logic [15:0]   pmem_address;
    vc_way_t       lru_used_way, lru_way;

    victim_cache_ctrl #(.TAG_W(12), .LINE_W(128)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .l1_req        (l1_req),
        .l1_tag        (l1_tag),
        .l1_vict_vld   (l1_vict_vld),
        .l1_vict_dirty (l1_vict_dirty),
        .l1_vict_tag   (l1_vict_tag),
        .l1_vict_data  (l1_vict_data),
        .l1_resp       (l1_resp),
        .l1_rdata      (l1_rdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .lru_load      (lru_load),
        .lru_used_way  (lru_used_way),
        .lru_way       (lru_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference contents: one slot per way, plus backing memory.
    logic          mv [4];
    logic          md [4];
    logic [11:0]   mt [4];
    logic [127:0]  mdat [4];
    logic [127:0]  mem [int];

    function automatic logic [127:0] mem_rd(input logic [11:0] t);
        if (mem.exists(int'(t))) return mem[int'(t)];
        return {4{t, 20'h5A3C1}};
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    task automatic model_install(input int w, input logic dty,
                                 input logic [11:0] t, input logic [127:0] d);
        for (int i = 0; i < 4; i++)
            if (i != w && mv[i] && mt[i] == t) mv[i] = 1'b0;
        mv[w] = 1'b1;
        md[w] = dty;
        mt[w] = t;
        mdat[w] = d;
    endtask

    task automatic run_req(input logic [11:0] tag, input logic vvld,
                           input logic vdty, input logic [11:0] vtag,
                           input logic [127:0] vdata, input vc_way_t lru,
                           input bit jitter);
        int h, v, cyc, resp_cyc, rd_resp_cyc, nwr, nrd, wcnt, rcnt, lat;
        int lru_cnt, lru_at, lru_w;
        bit wb, both;
        logic [15:0] wr_addr, rd_addr;
        logic [127:0] wr_data, got_data, exp_hit;
        h = -1; v = 0; wb = 0; both = 0;
        resp_cyc = -1; rd_resp_cyc = -100;
        nwr = 0; nrd = 0; wcnt = 0; rcnt = 0; lat = 0;
        lru_cnt = 0; lru_at = -1; lru_w = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; got_data = '0;
        exp_hit = '0;
        for (int i = 0; i < 4; i++)
            if (mv[i] && mt[i] == tag) h = i;
        if (h >= 0) begin
            exp_hit = mdat[h];
        end else begin
            v = -1;
            for (int i = 3; i >= 0; i--) if (!mv[i]) v = i;
            if (v < 0) v = int'(lru);
            wb = mv[v] && md[v] && vvld;
        end
        l1_req = 1'b1;
        l1_tag = tag;
        l1_vict_vld = vvld;
        l1_vict_dirty = vdty;
        l1_vict_tag = vtag;
        l1_vict_data = vdata;
        lru_way = lru;
        for (cyc = 1; cyc <= 60 && resp_cyc < 0; cyc++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            pmem_rdata = rnd_line();
            if (jitter) lru_way = vc_way_t'($urandom_range(0, 3));
            if (pmem_read && pmem_write) both = 1;
            if (lru_load) begin
                lru_cnt++;
                lru_at = cyc;
                lru_w = int'(lru_used_way);
            end
            if (l1_resp) begin
                resp_cyc = cyc;
                got_data = l1_rdata;
            end else if (pmem_write) begin
                if (wcnt == 0) begin
                    nwr++;
                    wr_addr = pmem_address;
                    wr_data = pmem_wdata;
                    lat = $urandom_range(0, 3);
                end
                wcnt++;
                if (wcnt > lat) begin
                    mem[int'(pmem_address[15:4])] = pmem_wdata;
                    pmem_resp = 1'b1;
                    wcnt = 0;
                end
            end else if (pmem_read) begin
                if (rcnt == 0) begin
                    nrd++;
                    rd_addr = pmem_address;
                    lat = $urandom_range(0, 3);
                end
                rcnt++;
                if (rcnt > lat) begin
                    pmem_rdata = mem_rd(pmem_address[15:4]);
                    pmem_resp = 1'b1;
                    rd_resp_cyc = cyc;
                    rcnt = 0;
                end
            end
        end
        l1_req = 1'b0;
        check("resp_seen", 128'(resp_cyc > 0), 128'(1));
        check("rw_excl", 128'(both), 128'(0));
        if (h >= 0) begin
            check("hit_lat", 128'(resp_cyc), 128'(1));
            check("hit_data", got_data, exp_hit);
            check("hit_mem", 128'(nwr + nrd), 128'(0));
            check("hit_lru_cnt", 128'(lru_cnt), 128'(1));
            check("hit_lru_way", 128'(lru_w), 128'(h));
            check("hit_lru_at", 128'(lru_at), 128'(resp_cyc));
            if (vvld) model_install(h, vdty, vtag, vdata);
            else mv[h] = 1'b0;
        end else begin
            check("wb_cnt", 128'(nwr), 128'(wb));
            if (wb) begin
                check("wb_addr", 128'(wr_addr), 128'({mt[v], 4'h0}));
                check("wb_data", wr_data, mdat[v]);
            end
            check("rd_cnt", 128'(nrd), 128'(1));
            check("rd_addr", 128'(rd_addr), 128'({tag, 4'h0}));
            check("miss_data", got_data, mem_rd(tag));
            check("miss_lat", 128'(resp_cyc), 128'(rd_resp_cyc + 1));
            check("miss_lru_cnt", 128'(lru_cnt), 128'(vvld));
            if (vvld) begin
                check("miss_lru_way", 128'(lru_w), 128'(v));
                check("miss_lru_at", 128'(lru_at), 128'(resp_cyc));
            end
            if (wb) md[v] = 1'b0;
            if (vvld) model_install(v, vdty, vtag, vdata);
        end
        @(negedge clk);
        check("resp_pulse", 128'({l1_resp, lru_load}), 128'(0));
    endtask

    task automatic rand_req();
        logic [11:0] t, vt;
        t = 12'($urandom_range(0, 11));
        do vt = 12'($urandom_range(0, 11)); while (vt == t);
        run_req(t, $urandom_range(0, 3) != 0, 1'($urandom), vt,
                rnd_line(), vc_way_t'($urandom_range(0, 3)), 1'b1);
    endtask

    task automatic reset_mid();
        l1_req = 1'b1;
        l1_tag = 12'h0F0;
        l1_vict_vld = 1'b0;
        for (int n = 0; n < 20 && !pmem_read; n++) @(negedge clk);
        check("rst_fetch_seen", 128'(pmem_read), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_read_drop", 128'({pmem_read, pmem_write, l1_resp}), 128'(0));
        rst_n = 1'b1;
        l1_req = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] old_tag;
        rst_n = 1'b0;
        l1_req = 1'b0;
        l1_tag = '0;
        l1_vict_vld = 1'b0;
        l1_vict_dirty = 1'b0;
        l1_vict_tag = '0;
        l1_vict_data = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        lru_way = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_l1_resp", 128'(l1_resp), 128'(0));
        check("rst_pmem", 128'({pmem_read, pmem_write}), 128'(0));
        check("rst_addr", 128'(pmem_address), 128'(0));
        check("rst_lru", 128'(lru_load), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_req(12'h123, 1'b0, 1'b0, 12'h000, '0, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++)
            run_req(12'(12'h200 + k), 1'b1, 1'b0, 12'(k), rnd_line(), 2'd0, 1'b0);
        run_req(12'h002, 1'b1, 1'b1, 12'h0AA, rnd_line(), 2'd0, 1'b0);
        run_req(12'h050, 1'b1, 1'b0, 12'h060, rnd_line(), 2'd1, 1'b1);
        run_req(12'h070, 1'b1, 1'b0, 12'h080, rnd_line(), 2'd0, 1'b1);
        run_req(12'h001, 1'b0, 1'b0, 12'h000, '0, 2'd2, 1'b0);

        for (int n = 0; n < 200; n++) rand_req();

        old_tag = 12'h0F1;
        for (int i = 3; i >= 0; i--) if (mv[i]) old_tag = mt[i];
        reset_mid();
        run_req(old_tag, 1'b0, 1'b0, 12'h000, '0, 2'd0, 1'b0);
        for (int n = 0; n < 40; n++) rand_req();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
